range_sum_sequencer: RTL and testbench

Time-multiplexed controller for the nibble range-sum datapath. It arbitrates up to four requesters round-robin and latches the granted requester's 8×4-bit operand vector and range endpoints. It then walks the range one nibble per clock through a single shared 4-bit adder/accumulator and returns the 8-bit sum with a one-cycle valid pulse. It replaces the 7-adder combinational tree when several front-ends share one summing resource.

---
 rtl/range_sum_sequencer_if.sv | 23 ++
 rtl/range_sum_sequencer.sv | 141 ++++++++++++++
 tb/tb_range_sum_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/range_sum_sequencer_if.sv
// Request/grant and result bus between the range-sum front-ends and the shared sequencer.
interface range_sum_sequencer_if #(
   parameter int unsigned NREQ = 2
);
   logic [31:0]       I;
   logic [NREQ-1:0]   req;
   logic [6*NREQ-1:0] contr;
   logic [NREQ-1:0]   gnt;
   logic              busy;
   logic [7:0]        Y;
   logic              valid;
   logic [1:0]        owner;

   modport master (
      output I, req, contr,
      input  gnt, busy, Y, valid, owner
   );

   modport slave (
      input  I, req, contr,
      output gnt, busy, Y, valid, owner
   );
endinterface

// File: rtl/range_sum_sequencer.sv
// Round-robin arbitrated nibble range-sum engine: one shared 4-bit adder walks
// the granted requester's range one nibble per clock and returns an 8-bit sum.
module range_sum_sequencer #(
   parameter int unsigned NREQ = 2
) (
   input  logic                  CLK100MHZ,
   input  logic                  BTNC,
   input  logic                  BTNU,
   range_sum_sequencer_if.slave  bus
);

   localparam int unsigned NW = 4;
   localparam int unsigned AW = 7;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      ACC  = 1'b1
   } state_t;

   state_t          state_q;
   logic [1:0]      ptr_q;
   logic [31:0]     ireg_q;
   logic [2:0]      idx_q;
   logic [2:0]      hi_q;
   logic [AW-1:0]   acc_q;
   logic [1:0]      cur_q;
   logic [NREQ-1:0] gnt_q;
   logic            busy_q;
   logic [7:0]      y_q;
   logic            valid_q;
   logic [1:0]      owner_q;

   logic            found_d;
   logic [1:0]      pick_d;
   logic [NREQ-1:0] gnt_d;
   logic [2:0]      a_d;
   logic [2:0]      b_d;
   logic [2:0]      lo_d;
   logic [2:0]      hi_d;
   logic [1:0]      ptr_d;
   logic [NW-1:0]   nib_d;
   logic [AW-1:0]   sum_d;

   // Round-robin pick starting at ptr, endpoint ordering and the accumulator step.
   always_comb begin
      found_d = 1'b0;
      pick_d  = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         for (int j = 0; j < int'(NREQ); j++) begin
            if (!found_d && bus.req[j] && (j == ((int'(ptr_q) + i) % int'(NREQ)))) begin
               found_d = 1'b1;
               pick_d  = 2'(j);
            end
         end
      end

      gnt_d = '0;
      a_d   = '0;
      b_d   = '0;
      for (int j = 0; j < int'(NREQ); j++) begin
         if (2'(j) == pick_d) begin
            gnt_d[j] = 1'b1;
            a_d      = bus.contr[6*j+3 +: 3];
            b_d      = bus.contr[6*j +: 3];
         end
      end

      lo_d  = (a_d < b_d) ? a_d : b_d;
      hi_d  = (a_d < b_d) ? b_d : a_d;
      ptr_d = 2'((int'(pick_d) + 1) % int'(NREQ));
      nib_d = ireg_q[{idx_q, 2'b00} +: NW];
      sum_d = acc_q + AW'(nib_d);
   end

   // Sequencer FSM: grant and latch in IDLE, one nibble per clock in ACC.
   always_ff @(posedge CLK100MHZ or posedge BTNC) begin
      if (BTNC) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         ireg_q  <= '0;
         idx_q   <= '0;
         hi_q    <= '0;
         acc_q   <= '0;
         cur_q   <= '0;
         gnt_q   <= '0;
         busy_q  <= 1'b0;
         y_q     <= '0;
         valid_q <= 1'b0;
         owner_q <= '0;
      end else begin
         gnt_q   <= '0;
         valid_q <= 1'b0;
         if (BTNU) begin
            // Abort keeps ptr, so the interrupted requester gives up its turn.
            state_q <= IDLE;
            acc_q   <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (found_d) begin
                     gnt_q   <= gnt_d;
                     ireg_q  <= bus.I;
                     idx_q   <= lo_d;
                     hi_q    <= hi_d;
                     acc_q   <= '0;
                     cur_q   <= pick_d;
                     ptr_q   <= ptr_d;
                     busy_q  <= 1'b1;
                     state_q <= ACC;
                  end
               end
               ACC: begin
                  acc_q <= sum_d;
                  if (idx_q == hi_q) begin
                     y_q     <= {1'b0, sum_d};
                     owner_q <= cur_q;
                     valid_q <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     idx_q <= idx_q + 3'd1;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.gnt   = gnt_q;
   assign bus.busy  = busy_q;
   assign bus.Y     = y_q;
   assign bus.valid = valid_q;
   assign bus.owner = owner_q;

endmodule

// File: tb/tb_range_sum_sequencer.sv
// Directed bench for range_sum_sequencer with a result scoreboard.
module tb_range_sum_sequencer;

   localparam int unsigned NREQ = 2;
   localparam int unsigned CW   = 6 * NREQ;

   typedef struct packed {
      logic [1:0] own;
      logic [7:0] y;
   } exp_t;

   logic CLK100MHZ = 1'b0;
   logic BTNC;
   logic BTNU;

   range_sum_sequencer_if #(.NREQ(NREQ)) bus ();

   range_sum_sequencer #(.NREQ(NREQ)) dut (
      .CLK100MHZ (CLK100MHZ),
      .BTNC      (BTNC),
      .BTNU      (BTNU),
      .bus       (bus)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Independent reference: sum of nibbles between the two endpoints inclusive.
   function automatic logic [7:0] ref_sum(input logic [31:0] v, input logic [2:0] a, input logic [2:0] b);
      int lo;
      int hi;
      int s;
      lo = (a < b) ? int'(a) : int'(b);
      hi = (a < b) ? int'(b) : int'(a);
      s  = 0;
      for (int k = lo; k <= hi; k++) s += int'((v >> (4 * k)) & 32'hF);
      return 8'(s);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge CLK100MHZ);
      #1;
   endtask

   task automatic drive(input int r, input logic [31:0] iv, input logic [2:0] a, input logic [2:0] b);
      bus.I               = iv;
      bus.contr[6*r +: 6] = {a, b};
      bus.req[r]          = 1'b1;
   endtask

   task automatic wait_gnt(input logic [NREQ-1:0] eg, input int elat);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (bus.gnt == '0 && n < 20);
      chk("gnt", 32'(bus.gnt), 32'(eg));
      chk("gnt_latency", n, elat);
      chk("busy_at_gnt", 32'(bus.busy), 1);
      chk("valid_at_gnt", 32'(bus.valid), 0);
   endtask

   task automatic wait_valid(input int elat, input bit scramble);
      int   n;
      exp_t e;
      n = 0;
      do begin
         step();
         n++;
         if (scramble) begin
            bus.I     = $urandom;
            bus.contr = CW'($urandom);
         end
         if (!bus.valid) chk("busy_in_acc", 32'(bus.busy), 1);
      end while (!bus.valid && n < 40);
      chk("valid_seen", 32'(bus.valid), 1);
      chk("valid_latency", n, elat);
      chk("gnt_at_valid", 32'(bus.gnt), 0);
      chk("busy_at_valid", 32'(bus.busy), 0);
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         chk("Y", 32'(bus.Y), 32'(e.y));
         chk("owner", 32'(bus.owner), 32'(e.own));
      end
   endtask

   initial begin
      logic [31:0] iv;
      logic [2:0]  a;
      logic [2:0]  b;
      int          k;

      BTNC      = 1'b1;
      BTNU      = 1'b0;
      bus.req   = '0;
      bus.I     = '0;
      bus.contr = '0;
      repeat (2) @(posedge CLK100MHZ);
      #1;
      BTNC = 1'b0;
      chk("rst_Y", 32'(bus.Y), 0);
      chk("rst_valid", 32'(bus.valid), 0);
      chk("rst_gnt", 32'(bus.gnt), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_owner", 32'(bus.owner), 0);

      // Single request, range 5..2.
      drive(0, 32'h8765_4321, 3'd5, 3'd2);
      sb.push_back('{own: 2'd0, y: 8'd18});
      wait_gnt(2'b01, 1);
      bus.req = '0;
      wait_valid(4, 1'b0);

      // Swapped endpoints.
      drive(0, 32'h8765_4321, 3'd2, 3'd5);
      sb.push_back('{own: 2'd0, y: 8'd18});
      wait_gnt(2'b01, 1);
      bus.req = '0;
      wait_valid(4, 1'b0);

      // Single nibble at the top.
      drive(0, 32'hF000_0000, 3'd7, 3'd7);
      sb.push_back('{own: 2'd0, y: 8'd15});
      wait_gnt(2'b01, 1);
      bus.req = '0;
      wait_valid(1, 1'b0);

      // Full range of all-ones: maximum sum.
      drive(0, 32'hFFFF_FFFF, 3'd0, 3'd7);
      sb.push_back('{own: 2'd0, y: 8'd120});
      wait_gnt(2'b01, 1);
      bus.req = '0;
      wait_valid(8, 1'b0);

      // Inputs churn every cycle during accumulation.
      for (int t = 0; t < 3; t++) begin
         iv = $urandom;
         a  = 3'($urandom);
         b  = 3'($urandom);
         k  = ((a > b) ? int'(a) - int'(b) : int'(b) - int'(a)) + 1;
         drive(1, iv, a, b);
         sb.push_back('{own: 2'd1, y: ref_sum(iv, a, b)});
         wait_gnt(2'b10, 1);
         bus.req = '0;
         wait_valid(k, 1'b1);
      end

      // Both requesters held: grants alternate, back-to-back.
      drive(0, 32'h0123_4567, 3'd0, 3'd3);
      drive(1, 32'h0123_4567, 3'd7, 3'd4);
      for (int g = 0; g < 4; g++) begin
         if (g % 2 == 0) sb.push_back('{own: 2'd0, y: ref_sum(32'h0123_4567, 3'd0, 3'd3)});
         else            sb.push_back('{own: 2'd1, y: ref_sum(32'h0123_4567, 3'd7, 3'd4)});
      end
      for (int g = 0; g < 4; g++) begin
         wait_gnt((g % 2 == 0) ? 2'b01 : 2'b10, 1);
         wait_valid(4, 1'b0);
         if (g == 3) bus.req = '0;
      end

      // Clear in IDLE beats a pending request.
      drive(0, 32'h0000_0900, 3'd2, 3'd2);
      BTNU = 1'b1;
      step();
      BTNU = 1'b0;
      chk("btnu_idle_gnt", 32'(bus.gnt), 0);
      chk("btnu_idle_busy", 32'(bus.busy), 0);
      sb.push_back('{own: 2'd0, y: 8'd9});
      wait_gnt(2'b01, 1);
      bus.req = '0;
      wait_valid(1, 1'b0);

      // Abort a 6-nibble sum; the other requester is served next.
      drive(1, 32'h1234_5678, 3'd1, 3'd6);
      drive(0, 32'h1234_5678, 3'd0, 3'd0);
      wait_gnt(2'b10, 1);
      step();
      step();
      BTNU = 1'b1;
      step();
      BTNU = 1'b0;
      chk("abort_valid", 32'(bus.valid), 0);
      chk("abort_Y", 32'(bus.Y), 0);
      chk("abort_busy", 32'(bus.busy), 0);
      chk("abort_gnt", 32'(bus.gnt), 0);
      sb.push_back('{own: 2'd0, y: 8'd8});
      wait_gnt(2'b01, 1);
      bus.req = '0;
      wait_valid(1, 1'b0);

      // Leave a nonzero result from requester 1 before the async reset.
      drive(1, 32'h0000_0700, 3'd2, 3'd2);
      sb.push_back('{own: 2'd1, y: 8'd7});
      wait_gnt(2'b10, 1);
      bus.req = '0;
      wait_valid(1, 1'b0);

      // Async reset in the middle of a sum.
      drive(0, 32'h5555_5555, 3'd0, 3'd7);
      wait_gnt(2'b01, 1);
      bus.req = '0;
      step();
      step();
      #3;
      BTNC = 1'b1;
      #1;
      chk("async_Y", 32'(bus.Y), 0);
      chk("async_valid", 32'(bus.valid), 0);
      chk("async_gnt", 32'(bus.gnt), 0);
      chk("async_busy", 32'(bus.busy), 0);
      chk("async_owner", 32'(bus.owner), 0);
      #1;
      BTNC = 1'b0;
      drive(1, 32'h0003_0000, 3'd4, 3'd4);
      sb.push_back('{own: 2'd1, y: 8'd3});
      wait_gnt(2'b10, 1);
      bus.req = '0;
      wait_valid(1, 1'b0);

      chk("scoreboard_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
